pipo_arbiter: RTL
=================

# pipo_arbiter

Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in/parallel-out holding register among NREQ requesters. Each requester presents parallel data and raises a request. The block grants one requester at a time, loads that requester's data into the shared register, acknowledges, and then releases the grant. It sits between the requesting datapaths and the shared register, and it is the only writer of that register.

## Interface
- WIDTH, default 4: data width of the shared register.
- NREQ, default 4: number of requesters, minimum 2.
- IDW, default $clog2(NREQ): width of the owner index.

- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; bit i belongs to requester i.
- din  input  NREQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH].
- clr_req  input  1  synchronous request to zero the shared register.
- gnt  output  NREQ  one-hot grant, registered.
- ack  output  1  one-cycle load-complete strobe, registered.
- q  output  WIDTH  shared register contents.
- owner  output  IDW  index of the last requester whose data was loaded.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, LOAD, ACK.
- IDLE transitions:
  - If clr_req=1: q<=0, stay in IDLE, issue no grant. clr_req has priority over all req.
  - Else if any req bit is set: select winner w, set gnt<=onehot(w), go to LOAD.
  - Else: stay in IDLE.
- LOAD: q<=din[w], owner<=w, ack<=1, go to ACK. gnt is held.
- ACK: gnt<=0, ack<=0, ptr<=(w+1) mod NREQ, go to IDLE.
- Round-robin selection: w is the first set req bit, scanning indices ptr, ptr+1, … with wrap from NREQ-1 to 0. ptr resets to 0.
- A grant, once issued, always completes. If req[w] drops during LOAD or ACK, din[w] is still loaded at the end of LOAD.
- Requesters must hold din valid from gnt rise through the end of LOAD.
- A requester must drop req in the ACK cycle if it wants no further grant. A req still high in the following IDLE counts as a new request.
- clr_req sampled in LOAD or ACK is ignored. The requester must hold it until IDLE.
- gnt is never more than one-hot. ack is high only in ACK.
- Reset values: state=IDLE, q=0, gnt=0, ack=0, owner=0, busy=0, ptr=0.
- Reset asserted mid-transaction aborts it immediately. No ack is produced, and q takes its reset value.

## Timing
- Edge E0: in IDLE, req sampled with at least one bit set.
- After E0: gnt[w]=1, busy=1.
- Edge E1: din[w] sampled.
- After E1: q=din[w], owner=w, ack=1.
- After E2: gnt=0, ack=0, busy=0, back in IDLE.
- Grant latency is 1 cycle and load latency is 2 cycles from the sampled request.
- Minimum spacing between grants is 3 cycles. Sustained throughput is one load per 3 clocks.
- A clr_req taking effect at edge E makes q=0 after E. The earliest subsequent grant is sampled at E+1.
- All outputs are registered except busy, which decodes state combinationally. No combinational path exists from req or din to any output.

## Structure
- Package pipo_arbiter_pkg holds:
  - state typedef with encodings IDLE=2'b00, LOAD=2'b01, ACK=2'b10.
  - Function rr_pick(req, ptr), which returns the winner index.
- Sub-module pipo_load_reg: WIDTH-bit register with an asynchronous active-high clear, synchronous load enable, and synchronous zero.
  - pipo_arbiter drives load in LOAD and zero on an honoured clr_req.
- The remaining FSM, pointer and grant logic stay in pipo_arbiter.

## Test plan
- Reset: assert clear mid-LOAD with req=4'b0010 → q=0, gnt=0, ack=0, owner=0, busy=0 asynchronously. After release, the next grant goes to requester 1.
- Single request: req=4'b0100, din[2]=4'hA → gnt=4'b0100 after E0, q=4'hA and ack=1 and owner=2 after E1, gnt=0 after E2.
- Fairness: hold req=4'b1111 with din[i]=i+1 → owners cycle 0,1,2,3,0, one load every 3 cycles, q values 1,2,3,4,1.
- Wrap: ptr=3 and req=4'b0011 → requester 0 wins. The next win with req still 4'b0011 goes to requester 1.
- Simultaneous events: clr_req=1 with req=4'b0001 in IDLE → q=0, no gnt that cycle, grant to requester 0 one cycle later. clr_req pulsed during ACK → ignored, q unchanged.
- Withdrawal: req[1] dropped the cycle after gnt[1] rises → load still completes, q=din[1], ack=1.

Source files
------------

// File: rtl/pipo_arbiter_pkg.sv
// pipo_arbiter_pkg: FSM state encoding and round-robin winner selection shared by the arbiter.
package pipo_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, ACK = 2'b10} state_t;
  localparam int MAX_NREQ = 32;
  // Scans downward so the lowest offset from ptr with a set bit is the final assignment.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] req, input int ptr, input int n);
    int idx;
    rr_pick = ptr;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      idx = ptr + k >= n ? ptr + k - n : ptr + k;
      if (k < n && req[idx[4:0]]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/pipo_load_reg.sv
// pipo_load_reg: shared holding register with async clear, sync zero and sync load.
module pipo_load_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge clear)
    if (clear) q <= '0;
    else q <= zero ? '0 : load ? d : q;
endmodule

// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin grant and load sequencing of one shared register among NREQ requesters.
module pipo_arbiter
  import pipo_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic              clr_req,
  output logic [NREQ-1:0]   gnt,
  output logic              ack,
  output logic [WIDTH-1:0]  q,
  output logic [IDW-1:0]    owner,
  output logic              busy
);
  state_t state, next;
  logic [IDW-1:0] ptr, w, pick;
  logic load, zero, start;
  assign pick  = IDW'(rr_pick(MAX_NREQ'(req), int'(ptr), NREQ));
  assign busy  = state != IDLE;
  assign start = state == IDLE && !clr_req && |req;
  assign load  = state == LOAD;
  assign zero  = state == IDLE && clr_req;
  always_comb begin
    next = state;
    next = state == IDLE ? (start ? LOAD : IDLE) : state == LOAD ? ACK : IDLE;
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) state <= IDLE;
    else state <= next;
  // w is latched at grant time so a withdrawn req cannot redirect the load.
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      ptr   <= '0;
      w     <= '0;
      gnt   <= '0;
      ack   <= 1'b0;
      owner <= '0;
    end else begin
      if (start) begin
        w   <= pick;
        gnt <= NREQ'(1) << pick;
      end
      if (state == LOAD) begin
        owner <= w;
        ack   <= 1'b1;
      end
      if (state == ACK) begin
        gnt <= '0;
        ack <= 1'b0;
        ptr <= w == IDW'(NREQ - 1) ? '0 : w + 1'b1;
      end
    end
  pipo_load_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .clear(clear),
    .load (load),
    .zero (zero),
    .d    (din[w*WIDTH +: WIDTH]),
    .q    (q)
  );
endmodule
